// File: rtl/debug_ring_hop_fifo.sv
// ---------------------------------------------------------------------------
// debug_ring_hop_fifo
//
// One hop of a debug ring: CHANNELS independent FIFOs of DEPTH entries, each
// entry holding {last, flit}. Every channel runs its own valid/ready
// handshake on both sides. Outputs are decoded purely from registered state,
// so no combinational path exists from in_* to out_* or from out_ready to
// in_ready.
//
// Modes (STORE_FWD):
//   0 : cut-through.       out_valid = (fill != 0)
//   1 : store-and-forward. out_valid = (complete packets held != 0), so a
//       packet is only released once its last flit is buffered.
//
// Optional feature, selected by macro DEBUG_RING_HOP_STATS_EN:
//   adds output pkt_count, one wrapping 16-bit counter per channel of
//   packets forwarded (pops with last=1).
//
// Ports:
//   clk        input   clock
//   rst        input   synchronous reset, active low
//   in_flit    input   [CHANNELS*FLIT_WIDTH] upstream data, channel c at
//                      [c*FLIT_WIDTH +: FLIT_WIDTH]
//   in_last    input   [CHANNELS] upstream end-of-packet
//   in_valid   input   [CHANNELS] upstream valid
//   in_ready   output  [CHANNELS] upstream ready (fill < DEPTH)
//   out_flit   output  [CHANNELS*FLIT_WIDTH] downstream data (0 when idle)
//   out_last   output  [CHANNELS] downstream end-of-packet (0 when idle)
//   out_valid  output  [CHANNELS] downstream valid
//   out_ready  input   [CHANNELS] downstream ready
//   fill       output  [CHANNELS*($clog2(DEPTH)+1)] per-channel occupancy
//   pkt_count  output  [CHANNELS*16] packets forwarded (stats build only)
// ---------------------------------------------------------------------------
module debug_ring_hop_fifo #(
  parameter int CHANNELS    = 2,
  parameter int FLIT_WIDTH  = 16,
  parameter int DEPTH       = 4,
  parameter int STORE_FWD   = 0,
  parameter int MAX_PKT_LEN = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0]        in_flit,
  input  logic [CHANNELS-1:0]                   in_last,
  input  logic [CHANNELS-1:0]                   in_valid,
  output logic [CHANNELS-1:0]                   in_ready,
  output logic [CHANNELS*FLIT_WIDTH-1:0]        out_flit,
  output logic [CHANNELS-1:0]                   out_last,
  output logic [CHANNELS-1:0]                   out_valid,
  input  logic [CHANNELS-1:0]                   out_ready,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0] fill
`ifdef DEBUG_RING_HOP_STATS_EN
  ,
  output logic [CHANNELS*16-1:0]                pkt_count
`endif
);

  localparam int AW = $clog2(DEPTH);   // pointer width
  localparam int FW = AW + 1;          // occupancy width, holds 0..DEPTH
  localparam int EW = FLIT_WIDTH + 1;  // stored entry {last, flit}

  // Parameter sanity, rejected at elaboration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("debug_ring_hop_fifo: DEPTH must be a power of two and >= 2");
  end
  // A store-and-forward hop must be able to hold a whole packet, otherwise a
  // maximum-length packet would fill the FIFO without ever becoming eligible.
  if (STORE_FWD != 0 && DEPTH < MAX_PKT_LEN) begin : g_bad_sf_depth
    $error("debug_ring_hop_fifo: STORE_FWD needs DEPTH >= MAX_PKT_LEN");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [FW-1:0] r_fill;
    logic [EW-1:0] w_head;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;

    assign w_head     = r_mem[r_rptr];
    assign w_in_ready = (r_fill < FW'(DEPTH));
    assign w_push     = in_valid[c] & w_in_ready;
    assign w_pop      = w_out_valid & out_ready[c];

    // Storage array needs no reset: a stale entry is never visible because
    // the read side is gated by fill / packet count.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wptr] <= {in_last[c], in_flit[c*FLIT_WIDTH +: FLIT_WIDTH]};
      end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so the natural
    // binary overflow implements the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_fill <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_fill <= r_fill + FW'(1);
          2'b01:   r_fill <= r_fill - FW'(1);
          default: r_fill <= r_fill;
        endcase
      end
    end

    if (STORE_FWD != 0) begin : g_sf
      // Number of complete packets (last flits) currently buffered.
      logic [FW-1:0] r_pkt_cnt;
      logic          w_push_last;
      logic          w_pop_last;

      assign w_push_last = w_push & in_last[c];
      assign w_pop_last  = w_pop & w_head[FLIT_WIDTH];

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_pkt_cnt <= '0;
        end else begin
          case ({w_push_last, w_pop_last})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + FW'(1);
            2'b01:   r_pkt_cnt <= r_pkt_cnt - FW'(1);
            default: r_pkt_cnt <= r_pkt_cnt;
          endcase
        end
      end

      assign w_out_valid = (r_pkt_cnt != '0);
    end else begin : g_ct
      assign w_out_valid = (r_fill != '0);
    end

`ifdef DEBUG_RING_HOP_STATS_EN
    logic [15:0] r_pkt_count;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_pkt_count <= '0;
      end else if (w_pop && w_head[FLIT_WIDTH]) begin
        r_pkt_count <= r_pkt_count + 16'd1;  // wraps FFFF -> 0
      end
    end

    assign pkt_count[c*16 +: 16] = r_pkt_count;
`endif

    // Head entry is masked while nothing is eligible, which keeps the data
    // outputs at zero after reset and while idle.
    assign in_ready[c]                         = w_in_ready;
    assign out_valid[c]                        = w_out_valid;
    assign out_last[c]                         = w_out_valid & w_head[FLIT_WIDTH];
    assign out_flit[c*FLIT_WIDTH +: FLIT_WIDTH] =
      w_out_valid ? w_head[FLIT_WIDTH-1:0] : '0;
    assign fill[c*FW +: FW]                    = r_fill;
  end

endmodule
